// File: rtl/itype_pkg.sv
// itype_pkg
// Shared definitions for the RV32I OP-IMM execution controller:
//   - opcode / funct3 / funct7 encodings used by the decoder
//   - sign-extension fix-up mask
//   - controller state type
//   - one-hot ALU operation type (field order = enable order:
//     addi, ori, xori, andi, slli, srli, srai)
package itype_pkg;

   localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_XORI = 3'b100;
   localparam logic [2:0] F3_SRXI = 3'b101;
   localparam logic [2:0] F3_ORI  = 3'b110;
   localparam logic [2:0] F3_ANDI = 3'b111;

   localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
   localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;

   // Upper bits that a sign-extended 12-bit immediate sets when imm[11]=1
   localparam logic [31:0] SEXT_MASK = 32'hFFFF_F000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WB
   } state_t;

   typedef struct packed {
      logic addi;
      logic ori;
      logic xori;
      logic andi;
      logic slli;
      logic srli;
      logic srai;
   } op_t;

   localparam op_t OP_NONE = '0;

endpackage

// File: rtl/itype_decode.sv
// itype_decode
// Combinational decoder for one OP-IMM instruction word.
// Ports:
//   instr  in  32  captured instruction word
//   op     out  7  one-hot operation (all zero when illegal)
//   legal  out  1  instruction is a supported OP-IMM encoding
//   imm    out 12  immediate to present to the ALU (shift amount only for shifts)
//   rs1    out  5  source register field
//   rd     out  5  destination register field
module itype_decode
   import itype_pkg::*;
(
   input  logic [31:0] instr,
   output op_t         op,
   output logic        legal,
   output logic [11:0] imm,
   output logic [4:0]  rs1,
   output logic [4:0]  rd
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [11:0] imm_raw;
   logic [6:0]  funct7;
   logic        is_shift;

   assign opcode  = instr[6:0];
   assign rd      = instr[11:7];
   assign funct3  = instr[14:12];
   assign rs1     = instr[19:15];
   assign imm_raw = instr[31:20];
   assign funct7  = imm_raw[11:5];

   // funct3 101 is shared by srli/srai; funct7 picks which one, and any
   // other funct7 leaves op all-zero so the instruction reads as illegal.
   always_comb begin
      op = OP_NONE;
      if (opcode == OPCODE_OPIMM) begin
         case (funct3)
            F3_ADDI: op.addi = 1'b1;
            F3_ORI:  op.ori  = 1'b1;
            F3_XORI: op.xori = 1'b1;
            F3_ANDI: op.andi = 1'b1;
            F3_SLLI: op.slli = (funct7 == FUNCT7_ZERO);
            F3_SRXI: begin
               op.srli = (funct7 == FUNCT7_ZERO);
               op.srai = (funct7 == FUNCT7_SRA);
            end
            default: op = OP_NONE;
         endcase
      end
   end

   assign legal    = |op;
   assign is_shift = op.slli | op.srli | op.srai;

   // Shifts only ever see the 5-bit shift amount, so srai's funct7 bit
   // cannot leak into the ALU's shift distance.
   assign imm = is_shift ? {7'b0000000, imm_raw[4:0]} : imm_raw;

endmodule

// File: rtl/itype_exec_ctrl.sv
// itype_exec_ctrl
// Sequencer for the I-type immediate ALU. Accepts one OP-IMM instruction,
// reads rs1, fires exactly one ALU enable, corrects the zero-extended ALU
// result to RV32I sign-extended semantics, and writes rd back.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr/instr_ready   instruction handshake
//   rs1_addr / rs1_rdata     register file read (combinational data)
//   alu_*_en                 one-hot ALU enables (EXEC only)
//   alu_opnd / alu_imm       ALU operand and immediate
//   alu_result               ALU output (combinational)
//   rd_we / rd_waddr / rd_wdata   register write-back
//   done / illegal           retire / reject pulse
//   retired_cnt / illegal_cnt     saturating counters
module itype_exec_ctrl
   import itype_pkg::*;
#(
   parameter bit SEXT_FIXUP = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [31:0]      instr,
   output logic             instr_ready,
   output logic [4:0]       rs1_addr,
   input  logic [31:0]      rs1_rdata,
   output logic             alu_addi_en,
   output logic             alu_ori_en,
   output logic             alu_xori_en,
   output logic             alu_andi_en,
   output logic             alu_slli_en,
   output logic             alu_srli_en,
   output logic             alu_srai_en,
   output logic [31:0]      alu_opnd,
   output logic [11:0]      alu_imm,
   input  logic [31:0]      alu_result,
   output logic             rd_we,
   output logic [4:0]       rd_waddr,
   output logic [31:0]      rd_wdata,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_next;
   logic [31:0]      instr_q;
   logic [31:0]      rs1_q;
   logic [31:0]      result_q;
   logic [CNT_W-1:0] retired_q;
   logic [CNT_W-1:0] illegal_q;
   logic [31:0]      fixed_result;
   op_t              op;
   op_t              alu_en;
   logic             legal;
   logic [11:0]      imm;
   logic [4:0]       rs1_field;
   logic [4:0]       rd_field;
   logic             accept;

   itype_decode u_decode (
      .instr (instr_q),
      .op    (op),
      .legal (legal),
      .imm   (imm),
      .rs1   (rs1_field),
      .rd    (rd_field)
   );

   assign accept = instr_valid & instr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         instr_q   <= '0;
         rs1_q     <= '0;
         result_q  <= '0;
         retired_q <= '0;
         illegal_q <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            instr_q <= instr;
         end
         if (state == ST_READ) begin
            rs1_q <= rs1_rdata;
         end
         if (state == ST_EXEC) begin
            result_q <= alu_result;
         end
         if ((state == ST_READ) && !legal && (illegal_q != '1)) begin
            illegal_q <= illegal_q + CNT_ONE;
         end
         if ((state == ST_WB) && (retired_q != '1)) begin
            retired_q <= retired_q + CNT_ONE;
         end
      end
   end

   // The ALU treats the immediate as zero-extended. When imm[11] is set the
   // true RV32I immediate also has bits 31:12 set; each case below adds the
   // effect of those upper bits back in. Shifts are masked to imm[4:0] in
   // the decoder so imm[11] is always 0 for them.
   always_comb begin
      fixed_result = result_q;
      if (SEXT_FIXUP && imm[11]) begin
         if (op.addi) begin
            fixed_result = result_q - 32'h0000_1000;
         end else if (op.ori) begin
            fixed_result = result_q | SEXT_MASK;
         end else if (op.xori) begin
            fixed_result = result_q ^ SEXT_MASK;
         end else if (op.andi) begin
            fixed_result = result_q | (rs1_q & SEXT_MASK);
         end
      end
   end

   always_comb begin
      state_next  = state;
      instr_ready = 1'b0;
      rs1_addr    = '0;
      alu_en      = OP_NONE;
      alu_opnd    = '0;
      alu_imm     = '0;
      rd_we       = 1'b0;
      rd_waddr    = '0;
      rd_wdata    = '0;
      done        = 1'b0;
      illegal     = 1'b0;
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_next = ST_READ;
            end
         end
         ST_READ: begin
            rs1_addr = rs1_field;
            if (legal) begin
               state_next = ST_EXEC;
            end else begin
               state_next = ST_IDLE;
               done       = 1'b1;
               illegal    = 1'b1;
            end
         end
         ST_EXEC: begin
            alu_en     = op;
            alu_opnd   = rs1_q;
            alu_imm    = imm;
            state_next = ST_WB;
         end
         ST_WB: begin
            rd_waddr   = rd_field;
            rd_wdata   = fixed_result;
            rd_we      = (rd_field != 5'd0);
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign alu_addi_en = alu_en.addi;
   assign alu_ori_en  = alu_en.ori;
   assign alu_xori_en = alu_en.xori;
   assign alu_andi_en = alu_en.andi;
   assign alu_slli_en = alu_en.slli;
   assign alu_srli_en = alu_en.srli;
   assign alu_srai_en = alu_en.srai;

   assign retired_cnt = retired_q;
   assign illegal_cnt = illegal_q;

endmodule

// File: tb/tb_itype_exec_ctrl.sv
// tb_itype_exec_ctrl
// Self-checking bench for itype_exec_ctrl. Two instances run in lockstep on
// the same instruction stream: dut_a with the sign-extension fix-up and
// 16-bit counters, dut_b without the fix-up and with 2-bit counters so
// counter saturation is reached. Expected results come from RV32I
// semantics (dut_a) or zero-extended-immediate semantics (dut_b).
module tb_itype_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] regs [32];

   logic        a_instr_ready, b_instr_ready;
   logic [4:0]  a_rs1_addr, b_rs1_addr;
   logic [31:0] a_rs1_rdata, b_rs1_rdata;
   logic        a_addi, a_ori, a_xori, a_andi, a_slli, a_srli, a_srai;
   logic        b_addi, b_ori, b_xori, b_andi, b_slli, b_srli, b_srai;
   logic [31:0] a_alu_opnd, b_alu_opnd;
   logic [11:0] a_alu_imm, b_alu_imm;
   logic [31:0] a_alu_result, b_alu_result;
   logic        a_rd_we, b_rd_we;
   logic [4:0]  a_rd_waddr, b_rd_waddr;
   logic [31:0] a_rd_wdata, b_rd_wdata;
   logic        a_done, b_done, a_illegal, b_illegal;
   logic [15:0] a_retired_cnt, a_illegal_cnt;
   logic [1:0]  b_retired_cnt, b_illegal_cnt;
   logic [6:0]  a_en, b_en;

   int checks = 0;
   int failures = 0;
   int exp_retired = 0;
   int exp_illegal = 0;

   always #5 clk = ~clk;

   assign a_en = {a_addi, a_ori, a_xori, a_andi, a_slli, a_srli, a_srai};
   assign b_en = {b_addi, b_ori, b_xori, b_andi, b_slli, b_srli, b_srai};

   assign a_rs1_rdata = regs[a_rs1_addr];
   assign b_rs1_rdata = regs[b_rs1_addr];

   // External ALU: immediate zero-extended; shift distance is the whole
   // alu_imm value, so an unmasked srai immediate would corrupt the result.
   function automatic logic [31:0] aluModel(input logic [6:0] en, input logic [31:0] a,
                                            input logic [11:0] i);
      logic [31:0] z;
      z = {20'b0, i};
      case (en)
         7'b1000000: return a + z;
         7'b0100000: return a | z;
         7'b0010000: return a ^ z;
         7'b0001000: return a & z;
         7'b0000100: return a << z;
         7'b0000010: return a >> z;
         7'b0000001: return $signed(a) >>> z;
         default:    return 32'h0;
      endcase
   endfunction

   assign a_alu_result = aluModel(a_en, a_alu_opnd, a_alu_imm);
   assign b_alu_result = aluModel(b_en, b_alu_opnd, b_alu_imm);

   itype_exec_ctrl #(.SEXT_FIXUP(1'b1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(a_instr_ready), .rs1_addr(a_rs1_addr), .rs1_rdata(a_rs1_rdata),
      .alu_addi_en(a_addi), .alu_ori_en(a_ori), .alu_xori_en(a_xori), .alu_andi_en(a_andi),
      .alu_slli_en(a_slli), .alu_srli_en(a_srli), .alu_srai_en(a_srai),
      .alu_opnd(a_alu_opnd), .alu_imm(a_alu_imm), .alu_result(a_alu_result),
      .rd_we(a_rd_we), .rd_waddr(a_rd_waddr), .rd_wdata(a_rd_wdata),
      .done(a_done), .illegal(a_illegal),
      .retired_cnt(a_retired_cnt), .illegal_cnt(a_illegal_cnt)
   );

   itype_exec_ctrl #(.SEXT_FIXUP(1'b0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(b_instr_ready), .rs1_addr(b_rs1_addr), .rs1_rdata(b_rs1_rdata),
      .alu_addi_en(b_addi), .alu_ori_en(b_ori), .alu_xori_en(b_xori), .alu_andi_en(b_andi),
      .alu_slli_en(b_slli), .alu_srli_en(b_srli), .alu_srai_en(b_srai),
      .alu_opnd(b_alu_opnd), .alu_imm(b_alu_imm), .alu_result(b_alu_result),
      .rd_we(b_rd_we), .rd_waddr(b_rd_waddr), .rd_wdata(b_rd_wdata),
      .done(b_done), .illegal(b_illegal),
      .retired_cnt(b_retired_cnt), .illegal_cnt(b_illegal_cnt)
   );

   // Which enable an instruction should raise (addi..srai, MSB first);
   // zero means the instruction must be rejected.
   function automatic logic [6:0] refOp(input logic [31:0] w);
      if (w[6:0] != 7'b0010011) return 7'b0;
      case (w[14:12])
         3'd0: return 7'b1000000;
         3'd6: return 7'b0100000;
         3'd4: return 7'b0010000;
         3'd7: return 7'b0001000;
         3'd1: return (w[31:25] == 7'h00) ? 7'b0000100 : 7'b0;
         3'd5: begin
            if (w[31:25] == 7'h00) return 7'b0000010;
            if (w[31:25] == 7'h20) return 7'b0000001;
            return 7'b0;
         end
         default: return 7'b0;
      endcase
   endfunction

   // Architectural result: sign-extended immediate when sext=1, otherwise
   // the raw zero-extended-immediate result.
   function automatic logic [31:0] refResult(input logic [31:0] w, input logic [31:0] rs1v,
                                             input bit sext);
      logic [31:0] iv;
      logic [4:0]  sh;
      iv = sext ? {{20{w[31]}}, w[31:20]} : {20'b0, w[31:20]};
      sh = w[24:20];
      case (refOp(w))
         7'b1000000: return rs1v + iv;
         7'b0100000: return rs1v | iv;
         7'b0010000: return rs1v ^ iv;
         7'b0001000: return rs1v & iv;
         7'b0000100: return rs1v << sh;
         7'b0000010: return rs1v >> sh;
         7'b0000001: return $signed(rs1v) >>> sh;
         default:    return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] satCnt(input int n, input int maxv);
      return 32'((n > maxv) ? maxv : n);
   endfunction

   function automatic logic [31:0] mkI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Offers one instruction in IDLE and follows it to completion, checking
   // every cycle. Ends in the IDLE cycle right after WB (or after the reject),
   // so consecutive calls exercise back-to-back acceptance.
   task automatic applyStimulus(input logic [31:0] w);
      logic [6:0]  eop;
      logic [31:0] rs1v;
      logic [11:0] eimm;
      logic [4:0]  rd;
      eop  = refOp(w);
      rs1v = regs[w[19:15]];
      rd   = w[11:7];
      eimm = (eop[2:0] != 3'b0) ? {7'b0, w[24:20]} : w[31:20];
      checkOutput("A.instr_ready_idle", 32'(a_instr_ready), 32'd1);
      checkOutput("B.instr_ready_idle", 32'(b_instr_ready), 32'd1);
      instr       = w;
      instr_valid = 1'b1;
      tick();
      instr = $urandom;
      checkOutput("A.rs1_addr", 32'(a_rs1_addr), 32'(w[19:15]));
      checkOutput("B.rs1_addr", 32'(b_rs1_addr), 32'(w[19:15]));
      checkOutput("A.instr_ready_busy", 32'(a_instr_ready), 32'd0);
      if (eop == 7'b0) begin
         exp_illegal++;
         checkOutput("A.reject_ctrl", {22'b0, a_done, a_illegal, a_rd_we, a_en}, {22'b0, 3'b110, 7'b0});
         checkOutput("B.reject_ctrl", {22'b0, b_done, b_illegal, b_rd_we, b_en}, {22'b0, 3'b110, 7'b0});
         instr_valid = 1'b0;
         tick();
         checkOutput("A.illegal_cnt", 32'(a_illegal_cnt), satCnt(exp_illegal, 65535));
         checkOutput("B.illegal_cnt", 32'(b_illegal_cnt), satCnt(exp_illegal, 3));
         checkOutput("A.post_reject_done", {30'b0, a_done, a_instr_ready}, 32'd1);
      end else begin
         checkOutput("A.read_ctrl", {22'b0, a_done, a_illegal, a_rd_we, a_en}, 32'd0);
         checkOutput("B.read_ctrl", {22'b0, b_done, b_illegal, b_rd_we, b_en}, 32'd0);
         tick();
         checkOutput("A.exec_en", {23'b0, a_done, a_rd_we, a_en}, {25'b0, eop});
         checkOutput("B.exec_en", {23'b0, b_done, b_rd_we, b_en}, {25'b0, eop});
         checkOutput("A.alu_opnd", a_alu_opnd, rs1v);
         checkOutput("A.alu_imm", 32'(a_alu_imm), 32'(eimm));
         checkOutput("B.alu_imm", 32'(b_alu_imm), 32'(eimm));
         instr_valid = 1'b0;
         tick();
         checkOutput("A.wb_ctrl", {22'b0, a_done, a_illegal, a_rd_we, a_en},
                     {22'b0, 1'b1, 1'b0, (rd != 5'd0), 7'b0});
         checkOutput("B.wb_ctrl", {22'b0, b_done, b_illegal, b_rd_we, b_en},
                     {22'b0, 1'b1, 1'b0, (rd != 5'd0), 7'b0});
         checkOutput("A.rd_waddr", 32'(a_rd_waddr), 32'(rd));
         checkOutput("A.rd_wdata", a_rd_wdata, refResult(w, rs1v, 1'b1));
         checkOutput("B.rd_wdata", b_rd_wdata, refResult(w, rs1v, 1'b0));
         exp_retired++;
         tick();
         checkOutput("A.retired_cnt", 32'(a_retired_cnt), satCnt(exp_retired, 65535));
         checkOutput("B.retired_cnt", 32'(b_retired_cnt), satCnt(exp_retired, 3));
         checkOutput("A.post_wb_done", {30'b0, a_done, a_instr_ready}, 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [11:0] rimm;
      logic [2:0]  rf3;
      logic [6:0]  ropc;

      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      regs[0] = 32'h0;
      regs[1] = 32'h0000_0010;
      regs[2] = 32'h8000_0000;
      regs[6] = 32'h1234_ABCD;

      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = 32'h0;
      tick();
      tick();
      rst = 1'b0;

      $display("[TB] reset values");
      checkOutput("A.reset_ready", 32'(a_instr_ready), 32'd1);
      checkOutput("A.reset_outs", {22'b0, a_done, a_illegal, a_rd_we, a_en}, 32'd0);
      checkOutput("A.reset_cnts", {a_retired_cnt, a_illegal_cnt}, 32'd0);
      checkOutput("B.reset_cnts", {28'b0, b_retired_cnt, b_illegal_cnt}, 32'd0);

      $display("[TB] reset during EXEC aborts the instruction");
      instr       = mkI(12'hFFF, 5'd1, 3'd0, 5'd5, 7'b0010011);
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      checkOutput("A.abort_exec_en", 32'(a_en), 32'b1000000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("A.abort_ready", 32'(a_instr_ready), 32'd1);
      checkOutput("A.abort_outs", {22'b0, a_done, a_illegal, a_rd_we, a_en}, 32'd0);
      checkOutput("A.abort_cnts", {a_retired_cnt, a_illegal_cnt}, 32'd0);
      tick();
      checkOutput("A.abort_later", {29'b0, a_done, a_rd_we, a_instr_ready}, 32'd1);
      checkOutput("B.abort_later", {29'b0, b_done, b_rd_we, b_instr_ready}, 32'd1);

      $display("[TB] directed instructions");
      applyStimulus(mkI(12'hFFF, 5'd1, 3'd0, 5'd5, 7'b0010011));
      applyStimulus(mkI(12'h404, 5'd2, 3'd5, 5'd3, 7'b0010011));
      applyStimulus(mkI(12'hF00, 5'd6, 3'd7, 5'd7, 7'b0010011));
      applyStimulus(mkI(12'h023, 5'd1, 3'd1, 5'd4, 7'b0010011));
      applyStimulus(mkI(12'h000, 5'd1, 3'd0, 5'd4, 7'b0110011));
      checkOutput("A.illegal_cnt_two", 32'(a_illegal_cnt), 32'd2);
      applyStimulus(mkI(12'h005, 5'd1, 3'd0, 5'd0, 7'b0010011));
      applyStimulus(mkI(12'h800, 5'd1, 3'd6, 5'd9, 7'b0010011));
      applyStimulus(mkI(12'h801, 5'd6, 3'd4, 5'd10, 7'b0010011));
      applyStimulus(mkI(12'h020, 5'd6, 3'd2, 5'd11, 7'b0010011));

      $display("[TB] randomized instructions");
      for (int k = 0; k < 60; k++) begin
         rimm = 12'($urandom);
         rf3  = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: rimm[11:5] = 7'h00;
            1: rimm[11:5] = 7'h20;
            default: ;
         endcase
         ropc = ($urandom_range(0, 9) == 0) ? 7'b0110011 : 7'b0010011;
         applyStimulus(mkI(rimm, 5'($urandom), rf3, 5'($urandom), ropc));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/itype_exec_ctrl.md
Name: itype_exec_ctrl

Overview:
- Sequencer for the I-type immediate ALU (addi/ori/xori/andi/slli/srli/srai).
- Accepts one 32-bit RV32I OP-IMM instruction per handshake and reads rs1 from the external register file.
- Drives exactly one ALU enable plus the operand and immediate, then applies RV32I sign-extension fix-up and writes rd back.
- Sits between the instruction source and the ALU/register file.

Parameters:
- SEXT_FIXUP, 1, 1 = correct the zero-extended-immediate ALU result to RV32I sign-extended semantics; 0 = write alu_out unmodified.
- CNT_W, 16, width of the retired and illegal counters (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word
- instr_ready  out  1  controller can accept
- rs1_addr  out  5  register file read address
- rs1_rdata  in  32  register file read data (combinational)
- alu_addi_en, alu_ori_en, alu_xori_en, alu_andi_en, alu_slli_en, alu_srli_en, alu_srai_en  out  1 each  one-hot ALU enables
- alu_opnd  out  32  ALU register operand
- alu_imm  out  12  ALU immediate
- alu_result  in  32  ALU output (combinational)
- rd_we  out  1  write-back strobe
- rd_waddr  out  5  write-back address
- rd_wdata  out  32  write-back data
- done  out  1  one-cycle pulse, instruction retired or rejected
- illegal  out  1  valid with done; instruction rejected
- retired_cnt  out  CNT_W  count of legal instructions retired
- illegal_cnt  out  CNT_W  count of rejected instructions

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, instr_ready=1, all other outputs 0, both counters 0. rst asserted mid-instruction aborts it with no write, no done, and no count change.
- FSM IDLE -> READ -> EXEC -> WB -> IDLE. instr_ready=1 only in IDLE.
- Accept: instr_valid & instr_ready captures instr into a register; the source may change instr afterwards.
- READ: rs1_addr=instr[19:15]; rs1_rdata is captured at the end of the cycle.
- Decode: legal only if opcode instr[6:0]=0010011 and funct3/imm match one of these:
  - 000 addi
  - 110 ori
  - 100 xori
  - 111 andi
  - 001 slli, requires imm[11:5]=0000000
  - 101 srli, requires imm[11:5]=0000000
  - 101 srai, requires imm[11:5]=0100000
  - Any other combination (including funct3 010/011) is illegal.
- Illegal instruction: READ goes directly to IDLE. done=1 and illegal=1 for that cycle, no ALU enable, no rd_we, illegal_cnt increments (saturating).
- EXEC: exactly one enable high for one cycle, with alu_opnd=captured rs1 and alu_imm=imm. For shifts, alu_imm={7'b0, imm[4:0]} so srai's funct7 bit never reaches the shift amount. alu_result is captured at the end of EXEC. Enables are 0 in every other state.
- Fix-up when SEXT_FIXUP=1 and imm[11]=1 (s = 0xFFFFF000):
  - addi: result - 0x1000
  - ori: result | s
  - xori: result ^ s
  - andi: result | (rs1 & s)
  - Shifts and imm[11]=0: no change.
  - All arithmetic is mod 2^32.
- WB (one cycle):
  - rd_waddr=instr[11:7] and rd_wdata=fixed result.
  - rd_we=1 only if rd_waddr!=0. Writing x0 is suppressed but the instruction still retires.
  - done=1, illegal=0, retired_cnt increments (saturating at all-ones).
- Latency: accept at cycle N, write/done at N+3. Throughput is one instruction per 4 cycles. Back-to-back: a new accept is possible in the cycle after WB.
- instr_valid while busy is ignored; the source must hold it.

Decomposition:
- Shared package itype_pkg:
  - OPCODE_OPIMM constant
  - funct3 constants
  - FUNCT7_SRA constant
  - enumerated state type
  - 7-bit op one-hot type, in enable order addi, ori, xori, andi, slli, srli, srai
- One sub-module, itype_decode: combinational; instr -> op one-hot, legal, shamt-masked imm.
- Fix-up logic stays inline.

Test Plan:
- addi x5,x1,-1 with x1=0x00000010: ALU returns 0x0000100F; rd_we at cycle N+3, rd_waddr=5, rd_wdata=0x0000000F, alu_addi_en high only in EXEC.
- srai x3,x2,4 (imm=0x404) with x2=0x80000000: alu_imm=0x004, alu_srai_en pulse, rd_wdata=0xF8000000.
- andi x7,x6,0xF00 (imm=-256) with x6=0x1234ABCD: rd_wdata=0x1234AB00. Repeat with SEXT_FIXUP=0: rd_wdata=0x00000B00.
- Illegal: slli with imm[11:5]=0000001 and opcode 0110011: done+illegal at N+1, no enable, no rd_we, illegal_cnt=2.
- addi x0,x1,5: done at N+3, rd_we=0, retired_cnt increments. Then a back-to-back ori accepted the cycle after WB.
- Assert rst during EXEC: next cycle IDLE, instr_ready=1, no rd_we or done, counters unchanged.
